// File: rtl/depth_test_unit.sv
`default_nettype none
// ============================================================================
// Module      : depth_test_unit
// Description : Per-fragment Z test. Reads stored depth, compares it, optionally
//               writes it back, and forwards passing color downstream.
//               Optional depth-bounds kill enabled by DEPTH_BOUNDS_TEST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module depth_test_unit #(
    parameter int COLOR_WIDTH = 128,
    parameter int DEPTH_WIDTH = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [2:0]             depth_func_i,
    input  logic                   depth_write_en_i,
    input  logic [ADDR_WIDTH-1:0]  zbuf_base_i,
    input  logic [15:0]            zbuf_pitch_i,
`ifdef DEPTH_BOUNDS_TEST_EN
    input  logic [DEPTH_WIDTH-1:0] zmin_i,
    input  logic [DEPTH_WIDTH-1:0] zmax_i,
`endif
    input  logic [15:0]            frag_x_i,
    input  logic [15:0]            frag_y_i,
    input  logic [DEPTH_WIDTH-1:0] frag_depth_i,
    input  logic [COLOR_WIDTH-1:0] frag_color_i,
    input  logic                   frag_valid_i,
    output logic                   frag_ready_o,
    output logic                   zb_rd_req_o,
    output logic [ADDR_WIDTH-1:0]  zb_rd_addr_o,
    input  logic                   zb_rd_gnt_i,
    input  logic                   zb_rd_valid_i,
    input  logic [DEPTH_WIDTH-1:0] zb_rd_data_i,
    output logic                   zb_wr_req_o,
    output logic [ADDR_WIDTH-1:0]  zb_wr_addr_o,
    output logic [DEPTH_WIDTH-1:0] zb_wr_data_o,
    input  logic                   zb_wr_gnt_i,
    output logic [COLOR_WIDTH-1:0] color_o,
    output logic [15:0]            color_x_o,
    output logic [15:0]            color_y_o,
    output logic                   color_valid_o,
    input  logic                   color_ready_i,
    output logic                   busy_o,
    output logic [31:0]            pass_count_o,
    output logic [31:0]            kill_count_o
);

    typedef enum logic [2:0] {
        c_IDLE    = 3'd0,
        c_RD_REQ  = 3'd1,
        c_RD_WAIT = 3'd2,
        c_DECIDE  = 3'd3,
        c_WR_REQ  = 3'd4,
        c_OUT     = 3'd5
    } state_t;

    localparam logic [2:0] c_FUNC_NEVER    = 3'd0;
    localparam logic [2:0] c_FUNC_LESS     = 3'd1;
    localparam logic [2:0] c_FUNC_EQUAL    = 3'd2;
    localparam logic [2:0] c_FUNC_LEQUAL   = 3'd3;
    localparam logic [2:0] c_FUNC_GREATER  = 3'd4;
    localparam logic [2:0] c_FUNC_NOTEQUAL = 3'd5;
    localparam logic [2:0] c_FUNC_GEQUAL   = 3'd6;
    localparam logic [2:0] c_FUNC_ALWAYS   = 3'd7;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [15:0]            r_frag_x;
    logic [15:0]            r_frag_y;
    logic [DEPTH_WIDTH-1:0] r_frag_depth;
    logic [COLOR_WIDTH-1:0] r_frag_color;
    logic [2:0]             r_func;
    logic                   r_wen;
    logic                   r_force_kill;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DEPTH_WIDTH-1:0] r_stored;
    logic [31:0]            r_pass_count;
    logic [31:0]            r_kill_count;

    logic                   w_accept;
    logic                   w_skip_read;
    logic                   w_oob;
    logic                   w_pass;
    logic                   w_kill;
    logic                   w_pass_done;
    logic [31:0]            w_pix_idx;
    logic [ADDR_WIDTH-1:0]  w_addr;

    assign w_accept    = (r_state == c_IDLE) && enable_i && !rst_i && frag_valid_i;
    assign w_skip_read = (depth_func_i == c_FUNC_NEVER) || (depth_func_i == c_FUNC_ALWAYS);

    // Pixel index is 32-bit and wraps; the byte offset is index * 4.
    assign w_pix_idx = 32'(frag_y_i) * 32'(zbuf_pitch_i) + 32'(frag_x_i);
    assign w_addr    = zbuf_base_i + ADDR_WIDTH'({w_pix_idx[29:0], 2'b00});

`ifdef DEPTH_BOUNDS_TEST_EN
    assign w_oob = (frag_depth_i < zmin_i) || (frag_depth_i > zmax_i);
`else
    assign w_oob = 1'b0;
`endif

    always_comb begin
        w_pass = 1'b0;
        case (r_func)
            c_FUNC_NEVER:    w_pass = 1'b0;
            c_FUNC_LESS:     w_pass = (r_frag_depth <  r_stored);
            c_FUNC_EQUAL:    w_pass = (r_frag_depth == r_stored);
            c_FUNC_LEQUAL:   w_pass = (r_frag_depth <= r_stored);
            c_FUNC_GREATER:  w_pass = (r_frag_depth >  r_stored);
            c_FUNC_NOTEQUAL: w_pass = (r_frag_depth != r_stored);
            c_FUNC_GEQUAL:   w_pass = (r_frag_depth >= r_stored);
            c_FUNC_ALWAYS:   w_pass = 1'b1;
            default:         w_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        frag_ready_o  = 1'b0;
        zb_rd_req_o   = 1'b0;
        zb_wr_req_o   = 1'b0;
        color_valid_o = 1'b0;
        busy_o        = (r_state != c_IDLE);
        w_kill        = 1'b0;
        w_pass_done   = 1'b0;
        case (r_state)
            c_IDLE: begin
                frag_ready_o = enable_i && !rst_i;
                if (w_accept) begin
                    // Out-of-bounds fragments go straight to DECIDE as a forced kill.
                    w_next_state = (w_oob || w_skip_read) ? c_DECIDE : c_RD_REQ;
                end
            end
            c_RD_REQ: begin
                zb_rd_req_o = 1'b1;
                if (zb_rd_gnt_i) w_next_state = c_RD_WAIT;
            end
            c_RD_WAIT: begin
                if (zb_rd_valid_i) w_next_state = c_DECIDE;
            end
            c_DECIDE: begin
                if (w_pass && !r_force_kill) begin
                    w_next_state = r_wen ? c_WR_REQ : c_OUT;
                end else begin
                    w_kill       = 1'b1;
                    w_next_state = c_IDLE;
                end
            end
            c_WR_REQ: begin
                zb_wr_req_o = 1'b1;
                if (zb_wr_gnt_i) w_next_state = c_OUT;
            end
            c_OUT: begin
                color_valid_o = 1'b1;
                if (color_ready_i) begin
                    w_pass_done  = 1'b1;
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_frag_x     <= '0;
            r_frag_y     <= '0;
            r_frag_depth <= '0;
            r_frag_color <= '0;
            r_func       <= '0;
            r_wen        <= 1'b0;
            r_force_kill <= 1'b0;
            r_addr       <= '0;
            r_stored     <= '0;
        end else begin
            if (w_accept) begin
                r_frag_x     <= frag_x_i;
                r_frag_y     <= frag_y_i;
                r_frag_depth <= frag_depth_i;
                r_frag_color <= frag_color_i;
                r_func       <= depth_func_i;
                r_wen        <= depth_write_en_i;
                r_force_kill <= w_oob;
                r_addr       <= w_addr;
            end
            if ((r_state == c_RD_WAIT) && zb_rd_valid_i) begin
                r_stored <= zb_rd_data_i;
            end
        end
    end

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pass_count <= '0;
            r_kill_count <= '0;
        end else begin
            if (w_pass_done && (r_pass_count != '1)) r_pass_count <= r_pass_count + 32'd1;
            if (w_kill && (r_kill_count != '1))      r_kill_count <= r_kill_count + 32'd1;
        end
    end

    assign zb_rd_addr_o = r_addr;
    assign zb_wr_addr_o = r_addr;
    assign zb_wr_data_o = r_frag_depth;
    assign color_o      = r_frag_color;
    assign color_x_o    = r_frag_x;
    assign color_y_o    = r_frag_y;
    assign pass_count_o = r_pass_count;
    assign kill_count_o = r_kill_count;

endmodule
`default_nettype wire

// File: doc/depth_test_unit.md
Name: depth_test_unit

Overview:
- Per-fragment depth-test stage directly downstream of fragment_processor; consumes its shaded color and depth.
- Reads the stored Z value from the depth buffer, compares it against the fragment depth, and optionally writes the new depth back.
- Forwards surviving fragments' color to the blend/ROP stage.
- Processes one fragment at a time, blocking, in order.

Parameters:
- COLOR_WIDTH, 128, fragment color width.
- DEPTH_WIDTH, 32, depth value width, unsigned.
- ADDR_WIDTH, 32, depth-buffer byte address width.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous active-high reset.
- enable_i  in  1  accept new fragments when high.
- depth_func_i  in  3  compare function: 0 NEVER, 1 LESS, 2 EQUAL, 3 LEQUAL, 4 GREATER, 5 NOTEQUAL, 6 GEQUAL, 7 ALWAYS.
- depth_write_en_i  in  1  write passing depth back to the buffer.
- zbuf_base_i  in  ADDR_WIDTH  depth-buffer base byte address.
- zbuf_pitch_i  in  16  row pitch in pixels.
- frag_x_i / frag_y_i  in  16/16  pixel coordinate.
- frag_depth_i  in  DEPTH_WIDTH  fragment depth.
- frag_color_i  in  COLOR_WIDTH  shaded color.
- frag_valid_i  in  1  fragment valid.
- frag_ready_o  out  1  fragment accept.
- zb_rd_req_o  out  1  depth read request.
- zb_rd_addr_o  out  ADDR_WIDTH  read address.
- zb_rd_gnt_i  in  1  read grant.
- zb_rd_valid_i  in  1  read data valid.
- zb_rd_data_i  in  DEPTH_WIDTH  stored depth.
- zb_wr_req_o  out  1  depth write request.
- zb_wr_addr_o  out  ADDR_WIDTH  write address.
- zb_wr_data_o  out  DEPTH_WIDTH  write data.
- zb_wr_gnt_i  in  1  write grant.
- color_o  out  COLOR_WIDTH  passing color.
- color_x_o / color_y_o  out  16/16  passing coordinate.
- color_valid_o  out  1  output valid.
- color_ready_i  in  1  output accept.
- busy_o  out  1  high when state is not IDLE.
- pass_count_o  out  32  fragments passed.
- kill_count_o  out  32  fragments killed.

Behaviour:
- Reset: state IDLE. frag_ready_o, zb_rd_req_o, zb_wr_req_o, color_valid_o, busy_o = 0. All data outputs = 0. Both counters = 0.
- Reset asserted mid-operation: abandon the in-flight fragment, drop outstanding requests next cycle, leave counters at 0. A read returning after reset is ignored.
- frag_ready_o = 1 only in IDLE with enable_i = 1. A transfer occurs when valid && ready. On transfer, latch x, y, depth, color, depth_func_i and depth_write_en_i; config is sampled per fragment.
- Address = zbuf_base_i + ((y*pitch + x) << 2). 32-bit multiply/add, wraps modulo 2^ADDR_WIDTH, no saturation.
- States:
  - IDLE -> RD_REQ on accept. If func is NEVER or ALWAYS, skip the read and go to DECIDE.
  - RD_REQ: hold zb_rd_req_o and address stable until zb_rd_gnt_i, then -> RD_WAIT.
  - RD_WAIT: on zb_rd_valid_i, latch data -> DECIDE.
  - DECIDE (1 cycle): unsigned compare of frag vs stored.
    - Pass with write enabled -> WR_REQ.
    - Pass with write disabled -> OUT.
    - Fail -> IDLE, kill_count +1.
  - WR_REQ: hold request until zb_wr_gnt_i -> OUT.
  - OUT: color_valid_o held with stable data until color_ready_i. On handshake, pass_count +1 -> IDLE.
- Ordering: the depth write always completes before color is presented.
- Minimum latency, accept to color_valid_o, with grants and read data returned the same cycle they are needed:
  - read + write path: 5 cycles.
  - ALWAYS without write: 2 cycles.
- Counters saturate at 0xFFFF_FFFF.
- enable_i low only blocks new accepts; an in-flight fragment completes.
- Grant and valid inputs are ignored outside their own states.

Optional Feature:
- Macro: DEPTH_BOUNDS_TEST_EN.
- Defined:
  - Adds inputs zmin_i, zmax_i (DEPTH_WIDTH).
  - In the accept cycle, a fragment with depth < zmin_i or > zmax_i (unsigned, inclusive bounds) is killed with no depth-buffer traffic, then returns to IDLE next cycle with kill_count +1.
- Undefined: ports absent, no bounds check.

Test Plan:
- func = LESS, write enabled, frag depth 0x100, stored 0x200, x = 3, y = 2, pitch = 64, base 0x1000 -> rd_addr 0x120C, wr_data 0x100 at 0x120C, color output once, pass_count = 1.
- func = LESS, frag 0x300, stored 0x200 -> no write, no color_valid_o, kill_count = 1.
- func = ALWAYS, write disabled -> no rd/wr requests, color_valid_o 2 cycles after accept.
- Stall: hold color_ready_i = 0 for 10 cycles in OUT -> color_o stable, frag_ready_o = 0; release -> single transfer.
- Assert rst_i while in RD_WAIT, then return zb_rd_valid_i -> stays IDLE, no outputs, counters 0.
- With DEPTH_BOUNDS_TEST_EN, zmin 0x10, zmax 0x20, frag 0x21 -> killed with no zb_rd_req_o; frag 0x20 -> proceeds to read.
